// File: rtl/dsp_pkg.sv
// Shared types and constants for the audio DSP chain (ADC source, FIR, DAC).
package dsp_pkg;

  localparam int SAMPLE_WIDTH    = 16;
  // Cycles the downstream FIR needs between accepted samples.
  localparam int FIR_BUSY_CYCLES = 19;

  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_DONE   = 2'd3
  } adc_state_t;

  // A sample period must hold a full conversion (select, shift, done, one idle)
  // and must not be shorter than the FIR's processing time.
  function automatic bit adc_params_ok(input int width, input int sample_div,
                                       input int sclk_half);
    return (sclk_half >= 1) &&
           (sample_div >= 2 * width * sclk_half + 3) &&
           (sample_div >= FIR_BUSY_CYCLES + 1);
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate divider: one-cycle tick every SAMPLE_DIV enabled clock cycles.
module sample_tick_gen
  import dsp_pkg::*;
#(
  parameter int SAMPLE_DIV = 64
) (
  input  logic ck,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] div_r;

  // Count 0..SAMPLE_DIV-1 while enabled; park at zero while disabled
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      div_r <= '0;
    end else if (!en) begin
      div_r <= '0;
    end else if (div_r == DIV_LAST) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + CW'(1);
    end
  end

  assign tick = en && (div_r == DIV_LAST);

endmodule

// File: rtl/adc_sample_source.sv
// Serial ADC reader: on each sample tick, clocks a WIDTH-bit word out of the
// ADC (mode 0, MSB first) and presents it with a one-cycle ready pulse.
module adc_sample_source
  import dsp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int SAMPLE_DIV = 64,
  parameter int SCLK_HALF  = 1
) (
  input  logic                    ck,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    sdata,
  input  logic                    clr_overrun,
  output logic                    cs_n,
  output logic                    sclk,
  output logic signed [WIDTH-1:0] sample,
  output logic                    sample_ready,
  output logic                    overrun
);

  localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_HALF - 1);
  localparam logic [BW-1:0] BITS_ALL  = BW'(WIDTH);

  if (!adc_params_ok(WIDTH, SAMPLE_DIV, SCLK_HALF)) begin : g_param_check
    $error("adc_sample_source: SAMPLE_DIV/SCLK_HALF/WIDTH combination is illegal");
  end

  adc_state_t       state_r;
  logic [WIDTH-1:0] shift_r;
  logic [BW-1:0]    bit_cnt_r;
  logic [HW-1:0]    half_cnt_r;
  logic             tick_s;

  sample_tick_gen #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_tick (
    .ck   (ck),
    .rst_n(rst_n),
    .en   (en),
    .tick (tick_s)
  );

  // Conversion sequencer: select, shift WIDTH bits on sclk rising edges, publish
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cs_n         <= 1'b1;
      sclk         <= 1'b0;
      sample       <= '0;
      sample_ready <= 1'b0;
      shift_r      <= '0;
      bit_cnt_r    <= '0;
      half_cnt_r   <= '0;
    end else begin
      sample_ready <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          cs_n <= 1'b1;
          sclk <= 1'b0;
          if (tick_s) begin
            state_r <= ST_SELECT;
            cs_n    <= 1'b0;
          end
        end
        ST_SELECT: begin
          state_r    <= ST_SHIFT;
          half_cnt_r <= '0;
          bit_cnt_r  <= '0;
        end
        ST_SHIFT: begin
          if (half_cnt_r == HALF_LAST) begin
            half_cnt_r <= '0;
            sclk       <= ~sclk;
            if (!sclk) begin
              // The edge raising sclk captures the bit the ADC has held stable.
              shift_r   <= {shift_r[WIDTH-2:0], sdata};
              bit_cnt_r <= bit_cnt_r + BW'(1);
            end else if (bit_cnt_r == BITS_ALL) begin
              // Last falling edge: deselect and publish in the same cycle.
              state_r      <= ST_DONE;
              cs_n         <= 1'b1;
              sample       <= shift_r;
              sample_ready <= 1'b1;
            end
          end else begin
            half_cnt_r <= half_cnt_r + HW'(1);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          cs_n    <= 1'b1;
          sclk    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          cs_n    <= 1'b1;
          sclk    <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overrun: a tick outside IDLE is dropped and flagged; set beats clear
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (tick_s && (state_r != ST_IDLE)) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end else begin
      overrun <= overrun;
    end
  end

endmodule

// File: tb/tb_adc_sample_source.sv
// Self-checking bench for adc_sample_source: ADC serial model plus a scoreboard
// of expected samples, pulse-timing and sclk-shape checks on two configurations.
module tb_adc_sample_source;

  localparam int W = 16;

  logic ck;
  logic rst_n, en, sdata, clr_overrun;
  logic cs_n, sclk, sample_ready, overrun;
  logic signed [W-1:0] sample;

  logic rst3_n, en3, sdata3, clr3;
  logic cs3_n, sclk3, ready3, ovr3;
  logic signed [W-1:0] sample3;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard / monitor state
  logic [W-1:0] adc_q[$];
  int           exp_q[$];
  logic [W-1:0] cur_word = '0;
  int           bit_idx = W - 1;
  int  cyc = 0;
  int  exp_pulse = 0;
  int  pulse_cnt = 0;
  int  rise_cnt = 0;
  int  cs_fall_cyc = 0;
  bit  prev_cs = 1'b1;
  bit  prev_sclk = 1'b0;
  bit  aborted = 1'b0;
  bit  chk_stable = 1'b0;
  int  last_smp = 0;
  bit  done3 = 1'b0;

  adc_sample_source dut (
    .ck          (ck),
    .rst_n       (rst_n),
    .en          (en),
    .sdata       (sdata),
    .clr_overrun (clr_overrun),
    .cs_n        (cs_n),
    .sclk        (sclk),
    .sample      (sample),
    .sample_ready(sample_ready),
    .overrun     (overrun)
  );

  adc_sample_source #(
    .WIDTH     (W),
    .SAMPLE_DIV(100),
    .SCLK_HALF (3)
  ) dut3 (
    .ck          (ck),
    .rst_n       (rst3_n),
    .en          (en3),
    .sdata       (sdata3),
    .clr_overrun (clr3),
    .cs_n        (cs3_n),
    .sclk        (sclk3),
    .sample      (sample3),
    .sample_ready(ready3),
    .overrun     (ovr3)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic wait_pulses(input int target, input int max_cyc);
    int i = 0;
    while (pulse_cnt < target && i < max_cyc) begin
      @(posedge ck);
      #2;
      i++;
    end
    check("wait_pulses", pulse_cnt, target);
  endtask

  task automatic wait_rise(input int n);
    int i = 0;
    while (!(cs_n == 1'b0 && rise_cnt == n) && i < 300) begin
      @(posedge ck);
      #2;
      i++;
    end
    check("wait_rise", rise_cnt, n);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m_cyc;
    rst_n = 1'b0; en = 1'b0; clr_overrun = 1'b0; sdata = 1'b0;
    rst3_n = 1'b0; en3 = 1'b0; clr3 = 1'b0; sdata3 = 1'b0;

    fork
      // Monitor for dut: ADC model, scoreboard, timing and shape checks
      forever begin
        @(posedge ck);
        cyc++;
        #1;
        if (cs_n) begin
          bit_idx = W - 1;
        end else if (prev_cs) begin
          cur_word = (adc_q.size() > 0) ? adc_q.pop_front() : 16'h0000;
          exp_q.push_back(int'($signed(cur_word)));
          bit_idx = W - 1;
          rise_cnt = 0;
          cs_fall_cyc = cyc;
        end else if (prev_sclk && !sclk && bit_idx > 0) begin
          bit_idx--;
        end
        sdata = cur_word[bit_idx[3:0]];
        if (!prev_sclk && sclk && !cs_n) rise_cnt++;
        if (!prev_cs && cs_n) begin
          if (!aborted) begin
            check("sclk_rises", rise_cnt, W);
            check("cs_n_low_len", cyc - cs_fall_cyc, 2 * W + 1);
          end
          aborted = 1'b0;
        end
        if (!rst_n) last_smp = 0;
        if (sample_ready) begin
          pulse_cnt++;
          check("pulse_cycle", cyc, exp_pulse);
          exp_pulse = exp_pulse + 64;
          if (exp_q.size() == 0) check("sample_expected", 0, 1);
          else check("sample_value", int'(sample), exp_q.pop_front());
          last_smp = int'(sample);
        end else if (chk_stable) begin
          check("sample_stable", int'(sample), last_smp);
        end
        prev_cs = cs_n;
        prev_sclk = sclk;
      end

      // Second configuration: SCLK_HALF = 3, SAMPLE_DIV = 100
      begin
        logic [W-1:0] w3;
        int idx3, fall3, tog3, exp3, n3, p3;
        bit pcs3, psclk3;
        w3 = 16'hA5C3; idx3 = W - 1; fall3 = 0; tog3 = 0; p3 = 0;
        pcs3 = 1'b1; psclk3 = 1'b0;
        repeat (2) @(posedge ck);
        @(negedge ck) rst3_n = 1'b1;
        @(negedge ck) en3 = 1'b1;
        n3 = cyc;
        exp3 = n3 + 99 + 98;
        for (int c = 0; c < 450; c++) begin
          @(posedge ck);
          #1;
          if (cs3_n) begin
            idx3 = W - 1;
          end else if (pcs3) begin
            idx3 = W - 1;
            fall3 = cyc;
            tog3 = 0;
          end else if (psclk3 && !sclk3 && idx3 > 0) begin
            idx3--;
          end
          sdata3 = w3[idx3[3:0]];
          if (!cs3_n && !pcs3 && (sclk3 != psclk3)) begin
            if (tog3 > 0) check("sclk3_phase", cyc - tog3, 3);
            tog3 = cyc;
          end
          if (!pcs3 && cs3_n) check("cs3_low_len", cyc - fall3, 97);
          if (ready3) begin
            p3++;
            check("pulse3_cycle", cyc, exp3);
            check("pulse3_after_tick", cyc - (fall3 - 1), 98);
            check("sample3_value", int'(sample3), int'($signed(w3)));
            exp3 = exp3 + 100;
          end
          pcs3 = cs3_n;
          psclk3 = sclk3;
        end
        check("pulses3", p3, 3);
        check("overrun3", int'(ovr3), 0);
        done3 = 1'b1;
      end
    join_none

    // Reset state
    repeat (3) @(posedge ck);
    #1;
    check("rst_cs_n", int'(cs_n), 1);
    check("rst_sclk", int'(sclk), 0);
    check("rst_sample", int'(sample), 0);
    check("rst_ready", int'(sample_ready), 0);
    check("rst_overrun", int'(overrun), 0);
    @(negedge ck) rst_n = 1'b1;

    // First sample and a stream of corner values, 64 cycles apart
    adc_q = '{16'h8001, 16'h1234, 16'h7FFF, 16'h0000, 16'hFFFF};
    @(negedge ck);
    en = 1'b1;
    exp_pulse = cyc + 97;
    wait_pulses(1, 200);
    chk_stable = 1'b1;
    wait_pulses(5, 400);

    // Reset at the 8th sclk rising edge aborts the conversion
    adc_q.push_back(16'h5A5A);
    adc_q.push_back(16'hC3A5);
    wait_rise(8);
    aborted = 1'b1;
    rst_n = 1'b0;
    #1;
    check("abort_cs_n", int'(cs_n), 1);
    check("abort_sclk", int'(sclk), 0);
    check("abort_ready", int'(sample_ready), 0);
    check("abort_sample", int'(sample), 0);
    exp_q.delete();
    @(negedge ck);
    @(negedge ck);
    rst_n = 1'b1;
    exp_pulse = cyc + 97;
    wait_pulses(6, 200);

    // en dropped for 10 cycles mid-conversion
    adc_q.push_back(16'h0F0F);
    adc_q.push_back(16'hF0F0);
    wait_rise(5);
    @(negedge ck);
    en = 1'b0;
    repeat (10) @(negedge ck);
    en = 1'b1;
    m_cyc = cyc;
    wait_pulses(7, 100);
    exp_pulse = m_cyc + 97;
    wait_pulses(8, 200);

    // Forced ticks during SHIFT: overrun set, set wins over clear, then clear
    adc_q.push_back(16'h2468);
    adc_q.push_back(16'h1357);
    wait_rise(3);
    @(negedge ck);
    force dut.tick_s = 1'b1;
    @(negedge ck);
    release dut.tick_s;
    check("overrun_set", int'(overrun), 1);
    wait_rise(6);
    @(negedge ck);
    force dut.tick_s = 1'b1;
    clr_overrun = 1'b1;
    @(negedge ck);
    release dut.tick_s;
    clr_overrun = 1'b0;
    check("overrun_set_beats_clr", int'(overrun), 1);
    wait_pulses(9, 100);
    @(negedge ck);
    clr_overrun = 1'b1;
    @(negedge ck);
    clr_overrun = 1'b0;
    check("overrun_cleared", int'(overrun), 0);
    wait_pulses(10, 200);
    en = 1'b0;

    for (int i = 0; i < 1000 && !done3; i++) @(posedge ck);
    check("dut3_done", int'(done3), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
